// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D requesters, the memory arbiter and the line memory.
// The slave view belongs to the arbiter; the master view drives requests and memory responses.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single line memory.
// One transaction in flight, round-robin on contention, mandatory idle cycle between grants.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_READ  = 2'd1,
    D_READ  = 2'd2,
    D_WRITE = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-5){1'b1}}, 5'b0};

  state_t                r_state;
  logic                  r_last_grant_d;
  logic                  r_pmem_read;
  logic                  r_pmem_write;
  logic [ADDR_WIDTH-1:0] r_pmem_address;
  logic [LINE_WIDTH-1:0] r_pmem_wdata;

  logic w_i_pend;
  logic w_d_pend;
  logic w_grant_i;

  // I wins when it is alone, or when both wait and D was served last.
  assign w_i_pend  = bus.i_read;
  assign w_d_pend  = bus.d_read | bus.d_write;
  assign w_grant_i = w_i_pend & (~w_d_pend | r_last_grant_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_last_grant_d <= 1'b1;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state        <= I_READ;
            r_pmem_read    <= 1'b1;
            r_pmem_address <= bus.i_address & LINE_MASK;
            r_last_grant_d <= 1'b0;
          end else if (w_d_pend) begin
            r_last_grant_d <= 1'b1;
            r_pmem_address <= bus.d_address & LINE_MASK;
            // A simultaneous read+write request is served as a write.
            if (bus.d_write) begin
              r_state      <= D_WRITE;
              r_pmem_write <= 1'b1;
              r_pmem_wdata <= bus.d_wdata;
            end else begin
              r_state      <= D_READ;
              r_pmem_read  <= 1'b1;
            end
          end
        end
        default: begin
          if (bus.pmem_resp) begin
            r_state      <= IDLE;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.pmem_read    = r_pmem_read;
  assign bus.pmem_write   = r_pmem_write;
  assign bus.pmem_address = r_pmem_address;
  assign bus.pmem_wdata   = r_pmem_wdata;

  // Completion is steered by the current grant so a stray pmem_resp in IDLE goes nowhere.
  assign bus.i_resp  = (r_state == I_READ) & bus.pmem_resp;
  assign bus.d_resp  = ((r_state == D_READ) | (r_state == D_WRITE)) & bus.pmem_resp;
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the grant/response rules.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mem_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_inputs();
    bus.i_read     = 1'b0;
    bus.i_address  = '0;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_address  = '0;
    bus.d_wdata    = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    bus.i_read    = 1'b1;
    bus.d_write   = 1'b1;
    bus.pmem_resp = 1'b1;
    repeat (2) tick();
    checks++; if (bus.pmem_read !== 1'b0) begin failures++; $display("FAIL reset_pmem_read got=%0b exp=0", bus.pmem_read); end
    checks++; if (bus.pmem_write !== 1'b0) begin failures++; $display("FAIL reset_pmem_write got=%0b exp=0", bus.pmem_write); end
    checks++; if (bus.pmem_address !== 32'h0) begin failures++; $display("FAIL reset_pmem_address got=%h exp=0", bus.pmem_address); end
    checks++; if (bus.pmem_wdata !== 256'h0) begin failures++; $display("FAIL reset_pmem_wdata got=%h exp=0", bus.pmem_wdata); end
    checks++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin failures++; $display("FAIL reset_resp got i=%0b d=%0b exp=0/0", bus.i_resp, bus.d_resp); end
    // Release with I still pending: the first edge with rst=1 grants I (last grant defaults to D).
    bus.d_write   = 1'b0;
    bus.pmem_resp = 1'b0;
    bus.i_address = 32'h0000_00ff;
    rst = 1'b1;
    checks++; if (bus.pmem_read !== 1'b0) begin failures++; $display("FAIL reset_release_early got=%0b exp=0", bus.pmem_read); end
    tick();
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h0000_00e0) begin failures++; $display("FAIL reset_first_grant got rd=%0b addr=%h exp rd=1 addr=000000e0", bus.pmem_read, bus.pmem_address); end
  endtask

  task automatic test_i_only_read();
    logic [255:0] a;
    apply_reset();
    a = rnd_line();
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_1234;
    tick();
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0) begin failures++; $display("FAIL i_read_strobe got rd=%0b wr=%0b exp rd=1 wr=0", bus.pmem_read, bus.pmem_write); end
    checks++; if (bus.pmem_address !== 32'h0000_1220) begin failures++; $display("FAIL i_read_addr got=%h exp=00001220", bus.pmem_address); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin failures++; $display("FAIL i_read_early_resp got i=%0b d=%0b exp 0/0", bus.i_resp, bus.d_resp); end
    end
    tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = a;
    #1;
    checks++; if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0) begin failures++; $display("FAIL i_read_resp got i=%0b d=%0b exp i=1 d=0", bus.i_resp, bus.d_resp); end
    checks++; if (bus.i_rdata !== a) begin failures++; $display("FAIL i_read_rdata got=%h exp=%h", bus.i_rdata, a); end
    tick();
    bus.pmem_resp = 1'b0;
    bus.i_read    = 1'b0;
    #1;
    checks++; if (bus.pmem_read !== 1'b0 || bus.i_resp !== 1'b0) begin failures++; $display("FAIL i_read_done got rd=%0b i_resp=%0b exp 0/0", bus.pmem_read, bus.i_resp); end
  endtask

  task automatic test_d_write();
    logic [255:0] w;
    apply_reset();
    w = rnd_line();
    bus.d_write   = 1'b1;
    bus.d_address = 32'h8000_0040;
    bus.d_wdata   = w;
    tick();
    checks++; if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0) begin failures++; $display("FAIL d_write_strobe got wr=%0b rd=%0b exp wr=1 rd=0", bus.pmem_write, bus.pmem_read); end
    // Requester-side changes during the grant must not disturb the latched values.
    bus.d_address = 32'h1234_5678;
    bus.d_wdata   = ~w;
    tick();
    checks++; if (bus.pmem_address !== 32'h8000_0040) begin failures++; $display("FAIL d_write_addr got=%h exp=80000040", bus.pmem_address); end
    checks++; if (bus.pmem_wdata !== w) begin failures++; $display("FAIL d_write_wdata got=%h exp=%h", bus.pmem_wdata, w); end
    bus.pmem_resp = 1'b1;
    #1;
    checks++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin failures++; $display("FAIL d_write_resp got d=%0b i=%0b exp d=1 i=0", bus.d_resp, bus.i_resp); end
    tick();
    bus.pmem_resp = 1'b0;
    bus.d_write   = 1'b0;
    #1;
    checks++; if (bus.pmem_write !== 1'b0 || bus.d_resp !== 1'b0) begin failures++; $display("FAIL d_write_done got wr=%0b d_resp=%0b exp 0/0", bus.pmem_write, bus.d_resp); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_2000;
    bus.d_read    = 1'b1;
    bus.d_address = 32'h0000_3000;
    tick();
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h0000_2000) begin failures++; $display("FAIL simul_first_grant got rd=%0b addr=%h exp rd=1 addr=00002000", bus.pmem_read, bus.pmem_address); end
    bus.pmem_resp = 1'b1;
    #1;
    checks++; if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0) begin failures++; $display("FAIL simul_i_resp got i=%0b d=%0b exp i=1 d=0", bus.i_resp, bus.d_resp); end
    tick();
    bus.pmem_resp = 1'b0;
    bus.i_read    = 1'b0;
    checks++; if (bus.pmem_read !== 1'b0) begin failures++; $display("FAIL simul_idle_gap got rd=%0b exp=0", bus.pmem_read); end
    tick();
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h0000_3000) begin failures++; $display("FAIL simul_second_grant got rd=%0b addr=%h exp rd=1 addr=00003000", bus.pmem_read, bus.pmem_address); end
    bus.pmem_resp = 1'b1;
    #1;
    checks++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin failures++; $display("FAIL simul_d_resp got d=%0b i=%0b exp d=1 i=0", bus.d_resp, bus.i_resp); end
    tick();
    bus.pmem_resp = 1'b0;
    bus.i_read    = 1'b1;
    tick();
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h0000_2000) begin failures++; $display("FAIL simul_third_grant got rd=%0b addr=%h exp rd=1 addr=00002000", bus.pmem_read, bus.pmem_address); end
    bus.pmem_resp = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.d_write   = 1'b1;
    bus.d_address = 32'h0000_4400;
    bus.d_wdata   = rnd_line();
    tick();
    checks++; if (bus.pmem_write !== 1'b1) begin failures++; $display("FAIL rstmid_pre got wr=%0b exp=1", bus.pmem_write); end
    #1;
    rst           = 1'b0;
    bus.pmem_resp = 1'b1;
    #1;
    checks++; if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b0) begin failures++; $display("FAIL rstmid_strobe got wr=%0b rd=%0b exp 0/0", bus.pmem_write, bus.pmem_read); end
    checks++; if (bus.d_resp !== 1'b0 || bus.i_resp !== 1'b0) begin failures++; $display("FAIL rstmid_resp got d=%0b i=%0b exp 0/0", bus.d_resp, bus.i_resp); end
    tick();
    bus.pmem_resp = 1'b0;
    bus.d_write   = 1'b0;
    rst           = 1'b1;
    tick();
    checks++; if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b0) begin failures++; $display("FAIL rstmid_idle got wr=%0b rd=%0b exp 0/0", bus.pmem_write, bus.pmem_read); end
  endtask

  task automatic test_spurious_abort();
    apply_reset();
    bus.pmem_resp = 1'b1;
    #1;
    checks++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin failures++; $display("FAIL spurious_resp got i=%0b d=%0b exp 0/0", bus.i_resp, bus.d_resp); end
    tick();
    checks++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin failures++; $display("FAIL spurious_state got rd=%0b wr=%0b exp 0/0", bus.pmem_read, bus.pmem_write); end
    bus.pmem_resp = 1'b0;
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_5a5f;
    tick();
    bus.i_read = 1'b0;
    tick();
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h0000_5a40) begin failures++; $display("FAIL abort_hold got rd=%0b addr=%h exp rd=1 addr=00005a40", bus.pmem_read, bus.pmem_address); end
    bus.pmem_resp = 1'b1;
    #1;
    checks++; if (bus.i_resp !== 1'b1) begin failures++; $display("FAIL abort_resp got=%0b exp=1", bus.i_resp); end
    tick();
    bus.pmem_resp = 1'b0;
    checks++; if (bus.pmem_read !== 1'b0) begin failures++; $display("FAIL abort_done got rd=%0b exp=0", bus.pmem_read); end
  endtask

  task automatic test_rw_both();
    apply_reset();
    bus.d_read    = 1'b1;
    bus.d_write   = 1'b1;
    bus.d_address = 32'h0000_0100;
    tick();
    checks++; if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0) begin failures++; $display("FAIL rw_both got wr=%0b rd=%0b exp wr=1 rd=0", bus.pmem_write, bus.pmem_read); end
    bus.pmem_resp = 1'b1;
    tick();
    clear_inputs();
  endtask

  // Transaction-level model: one outstanding access; when free and both sides wait,
  // serve the side not served last; release one cycle after the memory answers.
  task automatic test_random();
    logic         busy, side_d, is_wr, last_d, ip, dp, exp_i, exp_d, srv_i, srv_d;
    logic [31:0]  exp_addr;
    logic [255:0] exp_wdata, rdata;
    int           op;
    apply_reset();
    busy = 1'b0; side_d = 1'b0; is_wr = 1'b0; last_d = 1'b1;
    srv_i = 1'b0; srv_d = 1'b0; exp_addr = '0; exp_wdata = '0;
    for (int c = 0; c < 3000; c++) begin
      checks++; if (bus.pmem_read !== (busy & ~is_wr)) begin failures++; $display("FAIL rand_pmem_read cyc=%0d got=%0b exp=%0b", c, bus.pmem_read, busy & ~is_wr); end
      checks++; if (bus.pmem_write !== (busy & is_wr)) begin failures++; $display("FAIL rand_pmem_write cyc=%0d got=%0b exp=%0b", c, bus.pmem_write, busy & is_wr); end
      if (busy) begin
        checks++; if (bus.pmem_address !== exp_addr) begin failures++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", c, bus.pmem_address, exp_addr); end
      end
      if (busy && is_wr) begin
        checks++; if (bus.pmem_wdata !== exp_wdata) begin failures++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", c, bus.pmem_wdata, exp_wdata); end
      end
      if (srv_i) bus.i_read = 1'b0;
      if (srv_d) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
      if (!bus.i_read && $urandom_range(0, 2) == 0) begin
        bus.i_read    = 1'b1;
        bus.i_address = $urandom;
      end
      if (!(bus.d_read || bus.d_write) && $urandom_range(0, 2) == 0) begin
        op = int'($urandom_range(0, 2));
        bus.d_read    = (op != 1);
        bus.d_write   = (op != 0);
        bus.d_address = $urandom;
        bus.d_wdata   = rnd_line();
      end
      rdata          = rnd_line();
      bus.pmem_rdata = rdata;
      bus.pmem_resp  = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      #1;
      exp_i = busy & ~side_d & bus.pmem_resp;
      exp_d = busy & side_d & bus.pmem_resp;
      checks++; if (bus.i_resp !== exp_i) begin failures++; $display("FAIL rand_i_resp cyc=%0d got=%0b exp=%0b", c, bus.i_resp, exp_i); end
      checks++; if (bus.d_resp !== exp_d) begin failures++; $display("FAIL rand_d_resp cyc=%0d got=%0b exp=%0b", c, bus.d_resp, exp_d); end
      if (exp_i) begin
        checks++; if (bus.i_rdata !== rdata) begin failures++; $display("FAIL rand_i_rdata cyc=%0d got=%h exp=%h", c, bus.i_rdata, rdata); end
      end
      if (exp_d) begin
        checks++; if (bus.d_rdata !== rdata) begin failures++; $display("FAIL rand_d_rdata cyc=%0d got=%h exp=%h", c, bus.d_rdata, rdata); end
      end
      srv_i = exp_i;
      srv_d = exp_d;
      if (busy) begin
        if (bus.pmem_resp) busy = 1'b0;
      end else begin
        ip = bus.i_read;
        dp = bus.d_read | bus.d_write;
        if (ip && (!dp || last_d)) begin
          busy = 1'b1; side_d = 1'b0; is_wr = 1'b0; last_d = 1'b0;
          exp_addr = {bus.i_address[31:5], 5'b0};
        end else if (dp) begin
          busy = 1'b1; side_d = 1'b1; is_wr = bus.d_write; last_d = 1'b1;
          exp_addr = {bus.d_address[31:5], 5'b0};
          if (bus.d_write) exp_wdata = bus.d_wdata;
        end
      end
      @(posedge clk);
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_i_only_read();
    test_d_write();
    test_simultaneous();
    test_reset_mid();
    test_spurious_abort();
    test_rw_both();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
